multicycle_conunit: RTL

Multi-cycle successor to the single-cycle MIPS control unit. A state machine sequences each instruction through IF/ID/EXE/MEM/WB and drives per-cycle write enables and mux selects to a shared-memory multi-cycle datapath. It adds a memory-ready handshake, an optional extended ALU op set, illegal-opcode flagging and a retired-instruction counter. It sits beside the datapath: Op/Func come from the instruction register, Z comes from the ALU.

---
 rtl/multicycle_conunit.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/multicycle_conunit.sv
// Multi-cycle MIPS control unit.
// Sequences each instruction through IF/ID/EXE/MEM/WB and drives the per-cycle
// write enables and mux selects of a shared-memory multi-cycle datapath.
//
// Ports:
//   Clk, Clrn        clock and synchronous active-low reset
//   Op, Func         opcode / function fields from the instruction register
//   Z                ALU zero flag (meaningful in EXE)
//   Mrdy             memory ready, completes an IF or MEM access
//   Pcwr, IRwr       PC / IR write enables
//   Iord             memory address select (0=PC, 1=ALU result)
//   Mrd, Wmem        memory read / write requests
//   Regrt, Se, Aluqb decode-level datapath selects
//   Aluc             ALU operation
//   Pcsrc            next-PC source (00 PC+4, 10 branch, 11 jump)
//   Reg2reg, Wreg    writeback source select / register file write enable
//   Ill              one-cycle illegal-instruction pulse in ID
//   State            current FSM state (IF=0 .. WB=4)
//   Icnt             retired-instruction counter
module multicycle_conunit #(
    parameter int unsigned EXT_OPS = 1,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             Clk,
    input  logic             Clrn,
    input  logic [5:0]       Op,
    input  logic [5:0]       Func,
    input  logic             Z,
    input  logic             Mrdy,
    output logic             Pcwr,
    output logic             IRwr,
    output logic             Iord,
    output logic             Mrd,
    output logic             Wmem,
    output logic             Regrt,
    output logic             Se,
    output logic             Aluqb,
    output logic [2:0]       Aluc,
    output logic [1:0]       Pcsrc,
    output logic             Reg2reg,
    output logic             Wreg,
    output logic             Ill,
    output logic [2:0]       State,
    output logic [CNT_W-1:0] Icnt
);

    typedef enum logic [2:0] {
        StIf  = 3'd0,
        StId  = 3'd1,
        StExe = 3'd2,
        StMem = 3'd3,
        StWb  = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             cnt_inc;
    logic             pcwr, irwr, mrd, wmem, wreg, ill;

    // Instruction decode
    logic r_op, i_add, i_sub, i_and, i_or, i_slt, i_xor;
    logic i_addi, i_andi, i_ori, i_lw, i_sw, i_beq, i_bne, i_j;
    logic alu_r, alu_i, legal, taken;

    assign r_op   = (Op == 6'b000000);
    assign i_add  = r_op && (Func == 6'b100000);
    assign i_sub  = r_op && (Func == 6'b100010);
    assign i_and  = r_op && (Func == 6'b100100);
    assign i_or   = r_op && (Func == 6'b100101);
    assign i_slt  = (EXT_OPS != 0) && r_op && (Func == 6'b101010);
    assign i_xor  = (EXT_OPS != 0) && r_op && (Func == 6'b100110);
    assign i_addi = (Op == 6'b001000);
    assign i_andi = (Op == 6'b001100);
    assign i_ori  = (Op == 6'b001101);
    assign i_lw   = (Op == 6'b100011);
    assign i_sw   = (Op == 6'b101011);
    assign i_beq  = (Op == 6'b000100);
    assign i_bne  = (Op == 6'b000101);
    assign i_j    = (Op == 6'b000010);

    assign alu_r = i_add | i_sub | i_and | i_or | i_slt | i_xor;
    assign alu_i = i_addi | i_andi | i_ori;
    assign legal = alu_r | alu_i | i_lw | i_sw | i_beq | i_bne | i_j;
    assign taken = (i_beq & Z) | (i_bne & ~Z);

    // Decode-level selects are valid in every state
    assign Regrt   = alu_i | i_lw | i_sw | i_beq | i_bne | i_j;
    assign Se      = i_addi | i_lw | i_sw | i_beq | i_bne;
    assign Aluqb   = alu_r | i_beq | i_bne | i_j;
    assign Reg2reg = ~i_lw;

    always_comb begin
        Aluc = 3'b000;
        if (i_sub || i_beq || i_bne)  Aluc = 3'b001;
        else if (i_and || i_andi)     Aluc = 3'b010;
        else if (i_or || i_ori)       Aluc = 3'b011;
        else if (i_slt)               Aluc = 3'b100;
        else if (i_xor)               Aluc = 3'b101;
    end

    always_comb begin
        state_d = state_q;
        pcwr    = 1'b0;
        irwr    = 1'b0;
        Iord    = 1'b0;
        mrd     = 1'b0;
        wmem    = 1'b0;
        wreg    = 1'b0;
        Pcsrc   = 2'b00;
        ill     = 1'b0;
        cnt_inc = 1'b0;
        case (state_q)
            StIf: begin
                mrd = 1'b1;
                if (Mrdy) begin
                    pcwr    = 1'b1;
                    irwr    = 1'b1;
                    state_d = StId;
                end
            end
            StId: begin
                if (i_j) begin
                    pcwr    = 1'b1;
                    Pcsrc   = 2'b11;
                    cnt_inc = 1'b1;
                    state_d = StIf;
                end else if (!legal) begin
                    ill     = 1'b1;
                    state_d = StIf;
                end else begin
                    state_d = StExe;
                end
            end
            StExe: begin
                if (i_beq || i_bne) begin
                    if (taken) begin
                        pcwr  = 1'b1;
                        Pcsrc = 2'b10;
                    end
                    cnt_inc = 1'b1;
                    state_d = StIf;
                end else if (i_lw || i_sw) begin
                    state_d = StMem;
                end else begin
                    state_d = StWb;
                end
            end
            StMem: begin
                Iord = 1'b1;
                mrd  = i_lw;
                wmem = i_sw;
                if (Mrdy) begin
                    if (i_lw) begin
                        state_d = StWb;
                    end else begin
                        cnt_inc = 1'b1;
                        state_d = StIf;
                    end
                end
            end
            StWb: begin
                wreg    = 1'b1;
                cnt_inc = 1'b1;
                state_d = StIf;
            end
            default: state_d = StIf;
        endcase
    end

    // Reset gates every side-effecting request so an aborted instruction writes nothing
    assign Pcwr = Clrn & pcwr;
    assign IRwr = Clrn & irwr;
    assign Mrd  = Clrn & mrd;
    assign Wmem = Clrn & wmem;
    assign Wreg = Clrn & wreg;
    assign Ill  = Clrn & ill;

    always_ff @(posedge Clk) begin
        if (!Clrn) begin
            state_q <= StIf;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (cnt_inc) cnt_q <= cnt_q + 1'b1;
        end
    end

    assign State = state_q;
    assign Icnt  = cnt_q;

endmodule
